// File: rtl/action_encoder.sv
// Button-to-action encoder: synchronizes and debounces six buttons, then emits one
// prioritized one-hot action per game tick, with a cooldown that throttles repeated jumps.
`timescale 1ns/1ps
module action_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_CYCLES     = 8,
  parameter int JUMP_COOLDOWN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] btn,
  output logic [5:0] action_out,
  output logic       action_valid,
  output logic       cooldown_active
);

  // state       | meaning
  // ST_READY    | a pending JUMP may be selected at the next tick
  // ST_COOLDOWN | JUMP suppressed; r_cd_cnt counts remaining ticks
  typedef enum logic {ST_READY, ST_COOLDOWN} state_t;

  localparam logic [5:0] ACT_RIGHT = 6'b100000;
  localparam logic [5:0] ACT_LEFT  = 6'b010000;
  localparam logic [5:0] ACT_WAIT  = 6'b001000;
  localparam logic [5:0] ACT_JUMP  = 6'b000100;
  localparam logic [5:0] ACT_KICK  = 6'b000010;
  localparam logic [5:0] ACT_PUNCH = 6'b000001;

  localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] TICK_LAST = 8'(TICK_CYCLES - 1);
  localparam logic [2:0] CD_INIT   = 3'(JUMP_COOLDOWN);
  localparam bit         CD_EN     = (JUMP_COOLDOWN > 0);

  logic [5:0]      r_sync1;
  logic [5:0]      r_sync2;
  logic [5:0]      r_deb;
  logic [5:0][3:0] r_db_cnt;
  logic [7:0]      r_tick_cnt;
  logic [5:0]      r_pending;
  logic [2:0]      r_cd_cnt;
  state_t          r_state;

  logic            w_tick;
  logic [5:0]      w_req;
  logic [5:0]      w_sel;
  logic            w_jump_ok;
  state_t          w_state_nxt;
  logic [2:0]      w_cd_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // A single cycle of agreement restarts the per-bit stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb    <= '0;
      r_db_cnt <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 8'd1;
    end
  end

  // Reloading from the debounced state at each tick lets a held button re-request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else if (w_tick) begin
      r_pending <= r_deb;
    end else begin
      r_pending <= r_pending | r_deb;
    end
  end

  assign w_req     = r_pending | r_deb;
  assign w_jump_ok = (r_state == ST_READY);

  always_comb begin
    w_sel = ACT_WAIT;
    if (w_req[0]) begin
      w_sel = ACT_PUNCH;
    end else if (w_req[1]) begin
      w_sel = ACT_KICK;
    end else if (w_req[2] && w_jump_ok) begin
      w_sel = ACT_JUMP;
    end else if (w_req[5] && !w_req[4]) begin
      w_sel = ACT_RIGHT;
    end else if (w_req[4] && !w_req[5]) begin
      w_sel = ACT_LEFT;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd_cnt;
    case (r_state)
      ST_READY: begin
        if (w_tick && (w_sel == ACT_JUMP) && CD_EN) begin
          w_state_nxt = ST_COOLDOWN;
          w_cd_nxt    = CD_INIT;
        end
      end
      ST_COOLDOWN: begin
        if (w_tick) begin
          w_cd_nxt = r_cd_cnt - 3'd1;
          if (r_cd_cnt == 3'd1) begin
            w_state_nxt = ST_READY;
          end
        end
      end
      default: begin
        w_state_nxt = ST_READY;
        w_cd_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_READY;
      r_cd_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cd_cnt <= w_cd_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      action_out      <= ACT_WAIT;
      action_valid    <= 1'b0;
      cooldown_active <= 1'b0;
    end else begin
      if (w_tick) begin
        action_out <= w_sel;
      end
      action_valid    <= w_tick;
      cooldown_active <= (w_state_nxt == ST_COOLDOWN);
    end
  end

endmodule

// File: doc/action_encoder.md
ACTION_ENCODER -- requirements
Module: action_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronized cycles before a button state change is accepted (range 1..15).
REQ-002 SHALL have parameter TICK_CYCLES, default 8, meaning clock cycles per game tick (range 2..255).
REQ-003 SHALL have parameter JUMP_COOLDOWN, default 2, meaning ticks after an emitted JUMP during which JUMP is suppressed (range 0..7).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port btn  input  6  raw asynchronous buttons; bit5 move right, bit4 move left, bit3 wait, bit2 jump, bit1 kick, bit0 punch; 1 = pressed.
REQ-007 SHALL have port action_out  output  6  registered one-hot action code: 100000 move right, 010000 move left, 001000 wait, 000100 jump, 000010 kick, 000001 punch.
REQ-008 SHALL have port action_valid  output  1  registered one-cycle strobe marking a newly emitted action.
REQ-009 SHALL have port cooldown_active  output  1  registered; 1 while jump cooldown is in progress.

Function
REQ-010 SHALL pass each btn bit through a two-flop synchronizer before any other use.
REQ-011 SHALL keep a per-bit debounced state that changes only after the synchronized bit differs from it for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement clears that bit's counter.
REQ-012 SHALL keep a free-running tick counter 0..TICK_CYCLES-1; tick event = counter at TICK_CYCLES-1, after which it wraps to 0.
REQ-013 SHALL keep a 6-bit pending register: every cycle, pending |= debounced state; the cycle after a tick event, pending is loaded with the current debounced state only (press held across ticks re-requests).
REQ-014 SHALL, on the tick event cycle, select from pending by priority PUNCH > KICK > JUMP(if not suppressed) > move > WAIT.
REQ-015 SHALL treat move right and move left both pending (no higher action) as WAIT; a single move bit selects that move.
REQ-016 SHALL select WAIT when nothing (or only a suppressed JUMP) is pending.
REQ-017 SHALL register the selection into action_out and assert action_valid for exactly one cycle, one clock after the tick event; action_out holds until the next emission.
REQ-018 SHALL guarantee action_out is exactly one-hot in every cycle after reset.
REQ-019 SHALL implement jump FSM states READY and COOLDOWN: READY -> COOLDOWN when JUMP emitted and JUMP_COOLDOWN > 0; in COOLDOWN a 3-bit counter decrements on each tick event; COOLDOWN -> READY when it reaches 0 at a tick event.
REQ-020 SHALL suppress JUMP selection at a tick event while in COOLDOWN, including the tick on which the counter reaches 0; JUMP is selectable from the following tick.
REQ-021 SHALL drive cooldown_active = 1 exactly while the FSM is in COOLDOWN.
REQ-022 SHALL, with JUMP_COOLDOWN = 0, never enter COOLDOWN.

Reset
REQ-023 SHALL, while rst = 1, force action_out = 001000, action_valid = 0, cooldown_active = 0, FSM = READY, all counters, synchronizers, debounced states and pending bits = 0.
REQ-024 SHALL, on rst asserted mid-tick, discard pending requests; after release the first tick event occurs TICK_CYCLES cycles later.

Verification
REQ-025 SHALL pass: defaults, no buttons for 3 ticks -> three valid strobes 8 cycles apart, each action_out = 001000.
REQ-026 SHALL pass: btn[0] and btn[1] held 20 cycles -> emitted action 000001 (punch beats kick) on each tick while held.
REQ-027 SHALL pass: btn[2] pulse of 3 cycles (< 2 sync + 4 debounce) -> no jump emitted, action_out = 001000.
REQ-028 SHALL pass: btn[2] held 5 ticks, JUMP_COOLDOWN = 2 -> emissions 000100, 001000, 001000, 000100, 001000; cooldown_active high across the two suppressed ticks.
REQ-029 SHALL pass: btn[5] and btn[4] held together -> 001000; release btn[4] -> next tick after debounce 100000.
REQ-030 SHALL pass: btn[1] pressed then rst pulsed for 2 cycles mid-tick -> action_out = 001000, valid low, no kick emitted at first post-reset tick if btn released before reset.
